// File: rtl/inst_loader.sv
// Boot loader: takes a little-endian byte stream (word count, then words) and writes each word
// to consecutive instruction RAM addresses while holding the CPU in reset.
module inst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        debug,
  output logic        inst_ram_write_enable,
  output logic [31:0] inst_ram_write_data,
  output logic [31:0] inst_ram_write_address,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLen   = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StError = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] waddr_q, waddr_d;
  logic [15:0] words_q, words_d;

  logic        accept;
  logic [31:0] word_next;

  assign rx_ready  = (state_q == StLen) || (state_q == StData);
  assign accept    = rx_valid && rx_ready;
  // Bytes enter at the top so the first byte ends up in bits [7:0].
  assign word_next = {rx_data, shift_q[31:8]};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    wdata_d    = wdata_q;
    waddr_d    = waddr_q;
    words_d    = words_q;

    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d    = StLen;
          shift_d    = 32'h0;
          byte_cnt_d = 2'd0;
          tmo_d      = 32'h0;
        end
      end
      StLen, StData: begin
        if (accept) begin
          shift_d    = word_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          tmo_d      = 32'h0;
          if (byte_cnt_q == 2'd3) begin
            if (state_q == StLen) begin
              len_d   = word_next;
              idx_d   = 32'h0;
              words_d = 16'h0;
              if (word_next == 32'h0 || word_next > 32'(MAX_WORDS)) state_d = StError;
              else state_d = StData;
            end else begin
              wdata_d = word_next;
              waddr_d = BASE_ADDR + (idx_q << 2);
              state_d = StWrite;
            end
          end
        end else if (tmo_q == 32'(TIMEOUT - 1)) begin
          // Partial word is simply abandoned; nothing is written.
          state_d = StError;
        end else begin
          tmo_d = tmo_q + 32'h1;
        end
      end
      StWrite: begin
        idx_d   = idx_q + 32'h1;
        words_d = words_q + 16'h1;
        if (idx_q + 32'h1 == len_q) state_d = StDone;
        else state_d = StData;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      shift_q    <= 32'h0;
      byte_cnt_q <= 2'd0;
      len_q      <= 32'h0;
      idx_q      <= 32'h0;
      tmo_q      <= 32'h0;
      wdata_q    <= 32'h0;
      waddr_q    <= BASE_ADDR;
      words_q    <= 16'h0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      words_q    <= words_d;
    end
  end

  assign debug                  = (state_q == StLen) || (state_q == StData) ||
                                  (state_q == StWrite);
  assign inst_ram_write_enable  = (state_q == StWrite);
  assign inst_ram_write_data    = wdata_q;
  assign inst_ram_write_address = waddr_q;
  assign cpu_hold               = (state_q != StDone);
  assign done                   = (state_q == StDone);
  assign error                  = (state_q == StError);
  assign words_loaded           = words_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed and randomized loads of inst_loader checked against a word-list reference model.
module tb_inst_loader;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;  // exercises address wrap
  localparam int unsigned MAXW = 1024;
  localparam int unsigned TMO  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_ready, debug, wen, cpu_hold, done, error;
  logic [31:0] wdata, waddr;
  logic [15:0] words_loaded;

  int n_cmp = 0;
  int n_err = 0;
  int wen_count = 0;
  int wen_long = 0;
  logic wen_prev = 1'b0;
  logic [31:0] wq [0:15];

  inst_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW),
    .TIMEOUT  (TMO)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .rx_valid              (rx_valid),
    .rx_data               (rx_data),
    .rx_ready              (rx_ready),
    .debug                 (debug),
    .inst_ram_write_enable (wen),
    .inst_ram_write_data   (wdata),
    .inst_ram_write_address(waddr),
    .cpu_hold              (cpu_hold),
    .done                  (done),
    .error                 (error),
    .words_loaded          (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wen) wen_count <= wen_count + 1;
    if (wen && wen_prev) wen_long <= wen_long + 1;
    wen_prev <= wen;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", {31'h0, rx_ready}, 32'h1);
    @(negedge clk);  // accepted on the rising edge just passed
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_hold", {30'h0, cpu_hold, debug}, 32'h3);
  endtask

  // Load n words from wq[]; the model expects word i at BASE + 4*i.
  task automatic run_load(input logic [31:0] n, input int gap);
    int w0;
    logic ok;
    ok = (n != 0) && (n <= MAXW);
    w0 = wen_count;
    pulse_start();
    send_word(n, gap);
    if (ok) begin
      for (int i = 0; i < int'(n); i++) begin
        send_word(wq[i], gap);
        check("wen_latency", {31'h0, wen}, 32'h1);
        check("waddr", waddr, BASE + 32'(4 * i));
        check("wdata", wdata, wq[i]);
      end
      @(negedge clk);
      check("done", {29'h0, done, error, cpu_hold}, 32'h4);
      check("debug_rel", {31'h0, debug}, 32'h0);
      check("words_loaded", {16'h0, words_loaded}, n);
    end else begin
      check("err_flag", {29'h0, done, error, cpu_hold}, 32'h3);
    end
    check("wen_count", 32'(wen_count - w0), ok ? n : 32'h0);
  endtask

  initial begin
    int w0;
    #2 reset = 1'b0;
    #1;
    check("rst_ctl", {25'h0, rx_ready, debug, wen, cpu_hold, done, error, 1'b0}, 32'h8);
    check("rst_wdata", wdata, 32'h0);
    check("rst_waddr", waddr, BASE);
    check("rst_words", {16'h0, words_loaded}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back bytes, then gapped bytes
    wq[0] = 32'h1234_5678;
    wq[1] = 32'hDEAD_BEEF;
    run_load(32'd2, 0);
    run_load(32'd2, 3);

    // Restart after done
    wq[0] = 32'hDDCC_BBAA;
    run_load(32'd1, 0);

    // Illegal lengths
    run_load(32'd0, 0);
    run_load(32'd1025, 0);
    run_load(32'd1024 + 32'd4096, 1);

    // Stall mid-word until timeout
    w0 = wen_count;
    pulse_start();
    send_word(32'd1, 0);
    for (int k = 0; k < 3; k++) send_byte(8'h11 * 8'(k + 1), 0);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_early", {31'h0, error}, 32'h0);
    @(negedge clk);
    check("tmo_error", {30'h0, error, cpu_hold}, 32'h3);
    check("tmo_no_wen", 32'(wen_count - w0), 32'h0);

    // Asynchronous reset partway through a word
    pulse_start();
    send_word(32'd2, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_ctl", {25'h0, rx_ready, debug, wen, cpu_hold, done, error, 1'b0}, 32'h8);
    check("mid_rst_wdata", wdata, 32'h0);
    check("mid_rst_waddr", waddr, BASE);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wq[0] = 32'h0000_0001;
    run_load(32'd1, 0);

    // Randomized loads
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) wq[i] = $urandom;
      run_load(32'(n), $urandom_range(0, 3));
    end

    check("wen_single_cycle", 32'(wen_long), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
